// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame-based debounce.
// Rows are driven active-low one at a time. Columns are sampled on the last
// cycle of each row dwell. Every full frame is classified and fed to a
// press/release qualification FSM.
// Optional build macro: KEY_REPEAT_EN enables auto-repeat of key_valid while
// a key is held. The first repeat comes 500 cycles after acceptance, then one
// every 100 cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key accepted, waiting for a single-key frame
// DEBOUNCE | candidate seen, counting identical single-key frames
// PRESSED  | key accepted, key_held high, other keys ignored
// RELEASE  | candidate absent, counting clear frames before dropping key_held

module keypad_scan #(
   parameter int SCAN_MS    = 5,
   parameter int DEB_FRAMES = 4
) (
   input  logic       clk_1Khz,
   input  logic       rst,
   input  logic [3:0] key_col,
   output logic [3:0] key_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DEBOUNCE = 2'd1;
   localparam logic [1:0] ST_PRESSED  = 2'd2;
   localparam logic [1:0] ST_RELEASE  = 2'd3;

   localparam logic [7:0] DWELL_LAST = 8'(SCAN_MS - 1);
   localparam logic [3:0] DEB_TARGET = 4'(DEB_FRAMES);
   localparam logic       DEB_ONE    = (DEB_FRAMES == 1);

   logic [1:0]  state;
   logic [1:0]  row;
   logic [7:0]  dwell;
   logic [3:0]  cnt;
   logic [3:0]  cand;
   logic [15:0] snap;

   logic        row_last;
   logic        frame_eval;
   logic [15:0] frame;
   logic [4:0]  nbits;
   logic [3:0]  frame_code;
   logic        frame_single;
   logic        cand_hit;
   logic        cand_lost;
   logic [3:0]  cnt_inc;
   logic        rpt_fire;

   assign key_row    = ~(4'b0001 << row);
   assign row_last   = (dwell == DWELL_LAST);
   assign frame_eval = row_last && (row == 2'd3);

   // Row 3 is evaluated on the same edge it is sampled, so splice the live
   // column returns into the snapshot to form the complete frame.
   assign frame     = {~key_col, snap[11:0]};
   assign cand_hit  = frame[cand];
   assign cand_lost = frame_eval && !cand_hit;
   assign cnt_inc   = cnt + 4'd1;
   assign key_held  = (state == ST_PRESSED) || (state == ST_RELEASE);

   // Count closed keys in the frame and remember the index of the last one seen.
   always_comb begin
      nbits      = 5'd0;
      frame_code = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (frame[i]) begin
            nbits      = nbits + 5'd1;
            frame_code = 4'(i);
         end
      end
      frame_single = (nbits == 5'd1);
   end

   // Row stepping and settled column sampling into the frame snapshot.
   always_ff @(posedge clk_1Khz) begin
      if (rst) begin
         row   <= 2'd0;
         dwell <= 8'd0;
         snap  <= 16'd0;
      end else if (row_last) begin
         dwell                   <= 8'd0;
         row                     <= row + 2'd1;
         snap[{row, 2'b00} +: 4] <= ~key_col;
      end else begin
         dwell <= dwell + 8'd1;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam logic [8:0] REP_FIRST = 9'd499;
   localparam logic [8:0] REP_NEXT  = 9'd99;

   logic [8:0] rpt;

   // Repeat down-counter. It runs only in PRESSED and is preloaded everywhere
   // else, so re-entry from RELEASE restarts the full first-repeat delay.
   always_ff @(posedge clk_1Khz) begin
      if (rst) begin
         rpt <= REP_FIRST;
      end else if (state != ST_PRESSED) begin
         rpt <= REP_FIRST;
      end else if (rpt == 9'd0) begin
         rpt <= REP_NEXT;
      end else begin
         rpt <= rpt - 9'd1;
      end
   end

   assign rpt_fire = (rpt == 9'd0);
`else
   assign rpt_fire = 1'b0;
`endif

   // Press/release qualification; key_valid is a registered one-cycle pulse.
   always_ff @(posedge clk_1Khz) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         cand      <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (frame_eval && frame_single) begin
                  cand <= frame_code;
                  cnt  <= 4'd1;
                  if (DEB_ONE) begin
                     state     <= ST_PRESSED;
                     key_code  <= frame_code;
                     key_valid <= 1'b1;
                  end else begin
                     state <= ST_DEBOUNCE;
                  end
               end
            end
            ST_DEBOUNCE: begin
               if (frame_eval) begin
                  if (frame_single && (frame_code == cand)) begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= DEB_TARGET) begin
                        state     <= ST_PRESSED;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                     end
                  end else begin
                     state <= ST_IDLE;
                     cnt   <= 4'd0;
                  end
               end
            end
            ST_PRESSED: begin
               if (cand_lost) begin
                  if (DEB_ONE) begin
                     state <= ST_IDLE;
                     cnt   <= 4'd0;
                  end else begin
                     state <= ST_RELEASE;
                     cnt   <= 4'd1;
                  end
               end else if (rpt_fire) begin
                  key_valid <= 1'b1;
               end
            end
            default: begin
               if (frame_eval) begin
                  if (!cand_hit) begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= DEB_TARGET) begin
                        state <= ST_IDLE;
                        cnt   <= 4'd0;
                     end
                  end else begin
                     state <= ST_PRESSED;
                     cnt   <= 4'd0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan at default parameters.
// A behavioural key matrix pulls column c low while the row driving it is
// low and key (row, c) is closed.

module tb_keypad_scan;

   logic        clk_1Khz = 1'b0;
   logic        rst      = 1'b1;
   logic [3:0]  key_col;
   logic [3:0]  key_row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] keys     = 16'h0000;

   int n_tests = 0;
   int n_fail  = 0;

   keypad_scan dut (
      .clk_1Khz (clk_1Khz),
      .rst      (rst),
      .key_col  (key_col),
      .key_row  (key_row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk_1Khz = ~clk_1Khz;

   // Key matrix model.
   always_comb begin
      key_col = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keys[r*4 + c] && (key_row[r] === 1'b0)) key_col[c] = 1'b0;
         end
      end
   end

   // Runs n cycles sampling at negedge; counts key_valid pulses.
   task automatic run_cycles(input int n, output int pulses, output int first);
      pulses = 0;
      first  = -1;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk_1Khz);
         if (key_valid === 1'b1) begin
            pulses++;
            if (first < 0) first = k;
         end
      end
   endtask

   // Leaves the bench at the negedge after the last reset edge, rst low.
   task automatic do_reset();
      @(negedge clk_1Khz);
      rst = 1'b1;
      repeat (2) @(posedge clk_1Khz);
      @(negedge clk_1Khz);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      keys = 16'h0000;
      @(negedge clk_1Khz);
      rst = 1'b1;
      @(posedge clk_1Khz);
      @(negedge clk_1Khz);
      n_tests++;
      if (key_row !== 4'b1110) begin n_fail++; $display("FAIL reset_row: got %b, want 1110", key_row); end
      n_tests++;
      if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code: got %h, want 0", key_code); end
      n_tests++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", key_valid); end
      n_tests++;
      if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b, want 0", key_held); end
      rst = 1'b0;
   endtask

   task automatic test_idle_scan();
      logic [3:0] one;
      logic [3:0] exp_row;
      one = 4'b0001;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk_1Khz);
         exp_row = ~(one << ((k / 5) % 4));
         n_tests++;
         if (key_row !== exp_row) begin n_fail++; $display("FAIL idle_row c%0d: got %b, want %b", k, key_row, exp_row); end
         n_tests++;
         if (key_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid c%0d: got %b, want 0", k, key_valid); end
         n_tests++;
         if (key_held !== 1'b0) begin n_fail++; $display("FAIL idle_held c%0d: got %b, want 0", k, key_held); end
      end
   endtask

   task automatic test_hold();
      int pulses, first, drop;
      do_reset();
      keys = 16'h0200;
      run_cycles(300, pulses, first);
      n_tests++;
      if (pulses !== 1) begin n_fail++; $display("FAIL hold_pulses: got %0d, want 1", pulses); end
      n_tests++;
      if (first !== 80) begin n_fail++; $display("FAIL hold_latency: got %0d, want 80", first); end
      n_tests++;
      if (key_code !== 4'h9) begin n_fail++; $display("FAIL hold_code: got %h, want 9", key_code); end
      n_tests++;
      if (key_held !== 1'b1) begin n_fail++; $display("FAIL hold_held: got %b, want 1", key_held); end
      keys = 16'h0000;
      drop = -1;
      for (int k = 1; k <= 150; k++) begin
         @(negedge clk_1Khz);
         if (key_held !== 1'b1 && drop < 0) drop = k;
      end
      n_tests++;
      if (!(drop > 0 && drop <= 100)) begin n_fail++; $display("FAIL hold_release: got %0d cycles, want 1..100", drop); end
      n_tests++;
      if (key_code !== 4'h9) begin n_fail++; $display("FAIL hold_code_kept: got %h, want 9", key_code); end
   endtask

   task automatic test_short_press();
      int p1, p2, f;
      keys = 16'h0008;
      run_cycles(30, p1, f);
      keys = 16'h0000;
      run_cycles(120, p2, f);
      n_tests++;
      if (p1 + p2 !== 0) begin n_fail++; $display("FAIL short_pulses: got %0d, want 0", p1 + p2); end
      n_tests++;
      if (key_code !== 4'h9) begin n_fail++; $display("FAIL short_code: got %h, want 9", key_code); end
      n_tests++;
      if (key_held !== 1'b0) begin n_fail++; $display("FAIL short_held: got %b, want 0", key_held); end
   endtask

   task automatic test_multi();
      int p, f, p2, f2;
      do_reset();
      keys = 16'h0204;
      run_cycles(200, p, f);
      n_tests++;
      if (p !== 0) begin n_fail++; $display("FAIL multi_idle_pulses: got %0d, want 0", p); end
      n_tests++;
      if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_idle_held: got %b, want 0", key_held); end
      keys = 16'h0200;
      run_cycles(120, p, f);
      n_tests++;
      if (!(f > 0 && f <= 100)) begin n_fail++; $display("FAIL multi_latency: got %0d, want 1..100", f); end
      keys = 16'h0204;
      run_cycles(200, p2, f2);
      n_tests++;
      if (p + p2 !== 1) begin n_fail++; $display("FAIL multi_pulses: got %0d, want 1", p + p2); end
      n_tests++;
      if (key_code !== 4'h9) begin n_fail++; $display("FAIL multi_code: got %h, want 9", key_code); end
      n_tests++;
      if (key_held !== 1'b1) begin n_fail++; $display("FAIL multi_held: got %b, want 1", key_held); end
      keys = 16'h0000;
      run_cycles(150, p, f);
      n_tests++;
      if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_release: got %b, want 0", key_held); end
   endtask

   task automatic test_reset_mid();
      int p, f;
      do_reset();
      keys = 16'h0020;
      run_cycles(120, p, f);
      repeat (10) @(negedge clk_1Khz);
      n_tests++;
      if (key_held !== 1'b1 || p !== 1) begin n_fail++; $display("FAIL rmid_pre: held %b pulses %0d, want 1 and 1", key_held, p); end
      rst = 1'b1;
      @(posedge clk_1Khz);
      @(negedge clk_1Khz);
      n_tests++;
      if (key_held !== 1'b0) begin n_fail++; $display("FAIL rmid_held: got %b, want 0", key_held); end
      n_tests++;
      if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b, want 0", key_valid); end
      rst = 1'b0;
      run_cycles(150, p, f);
      n_tests++;
      if (!(f >= 80 && f <= 100)) begin n_fail++; $display("FAIL rmid_requal: got %0d, want 80..100", f); end
      n_tests++;
      if (p !== 1) begin n_fail++; $display("FAIL rmid_pulses: got %0d, want 1", p); end
      n_tests++;
      if (key_code !== 4'h5) begin n_fail++; $display("FAIL rmid_code: got %h, want 5", key_code); end
      keys = 16'h0000;
      run_cycles(150, p, f);
   endtask

   task automatic test_repeat();
      int times[8];
      int n, p, f;
`ifdef KEY_REPEAT_EN
      int exp_n = 4;
      int exp_t[4] = '{80, 580, 680, 780};
`else
      int exp_n = 1;
      int exp_t[1] = '{80};
`endif
      n = 0;
      do_reset();
      keys = 16'h8000;
      for (int k = 1; k <= 800; k++) begin
         @(negedge clk_1Khz);
         if (key_valid === 1'b1) begin
            if (n < 8) times[n] = k;
            n++;
         end
      end
      n_tests++;
      if (n !== exp_n) begin n_fail++; $display("FAIL repeat_count: got %0d, want %0d", n, exp_n); end
      for (int i = 0; i < exp_n; i++) begin
         n_tests++;
         if (i >= n || times[i] !== exp_t[i]) begin
            n_fail++;
            $display("FAIL repeat_time%0d: got %0d, want %0d", i, (i < n) ? times[i] : -1, exp_t[i]);
         end
      end
      n_tests++;
      if (key_code !== 4'hF) begin n_fail++; $display("FAIL repeat_code: got %h, want f", key_code); end
      keys = 16'h0000;
      run_cycles(150, p, f);
      n_tests++;
      if (key_held !== 1'b0 || p !== 0) begin n_fail++; $display("FAIL repeat_release: held %b pulses %0d, want 0 and 0", key_held, p); end
   endtask

   initial begin
      test_reset();
      test_idle_scan();
      test_hold();
      test_short_press();
      test_multi();
      test_reset_mid();
      test_repeat();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_MS, default 5: clk_1Khz cycles each row is driven per scan step (legal 2..255).
REQ-002 SHALL have parameter DEB_FRAMES, default 4: consecutive identical frames needed to accept a press or release (legal 1..15).
REQ-003 SHALL have port clk_1Khz  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_col  input  4  column returns, active-low, pulled up externally; column c low = key at (driven row, c) closed.
REQ-006 SHALL have port key_row  output  4  row drive, active-low one-cold; exactly one bit low at all times after reset.
REQ-007 SHALL have port key_code  output  4  code of last accepted key = {row[1:0], col[1:0]}.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse on acceptance of a new press.
REQ-009 SHALL have port key_held  output  1  high while an accepted key remains pressed.

Function
REQ-010 SHALL step row index 0,1,2,3,0,... every SCAN_MS cycles; key_row = ~(4'b0001 << row).
REQ-011 SHALL sample key_col only on the last cycle of each row dwell (settling), into a 16-bit frame snapshot bit row*4+col.
REQ-012 SHALL evaluate a frame once per 4*SCAN_MS cycles, on the cycle the row-3 sample is taken; evaluation uses the complete snapshot.
REQ-013 SHALL classify a frame as NONE (0 bits set), SINGLE (1 bit, code = its index) or MULTI (>=2 bits).
REQ-014 SHALL implement states IDLE, DEBOUNCE, PRESSED, RELEASE with a 4-bit frame counter cnt.
REQ-015 IDLE: SINGLE -> store cand=code, cnt=1, go DEBOUNCE (or directly PRESSED if DEB_FRAMES=1); NONE/MULTI -> stay.
REQ-016 DEBOUNCE: SINGLE with code==cand -> cnt+1; when cnt reaches DEB_FRAMES -> PRESSED, key_code<=cand, key_valid=1 for that one cycle; any other frame -> IDLE.
REQ-017 PRESSED: key_held=1; frame with cand bit set (other keys ignored) -> stay; cand bit clear -> RELEASE, cnt=1.
REQ-018 RELEASE: cand bit clear -> cnt+1, at DEB_FRAMES -> IDLE, key_held=0; cand bit set -> back to PRESSED, no key_valid.
REQ-019 key_code SHALL change only on acceptance; it holds its value through release and IDLE.
REQ-020 Press-to-key_valid latency SHALL be at most (DEB_FRAMES+1)*4*SCAN_MS cycles for a press stable from its onset (100 cycles at defaults).
REQ-021 A glitch shorter than one frame that disturbs DEBOUNCE SHALL restart qualification from IDLE; no partial acceptance.
REQ-022 Row and dwell counters SHALL wrap silently; no other sticky error state exists.

Reset
REQ-023 On rst high at a clock edge: state=IDLE, row=0, dwell=0, cnt=0, snapshot=0, key_row=4'b1110, key_code=0, key_valid=0, key_held=0.
REQ-024 Reset asserted mid-press SHALL drop key_held next cycle and require full re-qualification after release of rst; no key_valid during or on exit from reset.

Configuration
REQ-025 Macro KEY_REPEAT_EN: when defined, in PRESSED a repeat counter SHALL emit key_valid (same key_code) 500 cycles after acceptance, then every 100 cycles while held; counter clears on leaving PRESSED.
REQ-026 Without KEY_REPEAT_EN, exactly one key_valid per accepted press and no repeat logic is synthesised.

Verification
REQ-027 Reset then idle 200 cycles -> key_row cycles 1110,1101,1011,0111 every 5 cycles; key_valid never high; key_held=0.
REQ-028 Hold key (row 2, col 1) from cycle 0 for 300 cycles -> one key_valid within 100 cycles, key_code=4'h9, key_held high until at most 100 cycles after release.
REQ-029 Key (row 0, col 3) pressed for 30 cycles only -> no key_valid, key_code unchanged.
REQ-030 Keys 4'h9 and 4'h2 pressed together from idle -> no key_valid; press 4'h9 alone, then add 4'h2 while held -> single key_valid code 4'h9, no second event.
REQ-031 Assert rst for 1 cycle while 4'h5 is held (key_held=1) -> key_held=0 next cycle, key_valid reissued for 4'h5 only after re-qualification (<=100 cycles after rst low).
REQ-032 With KEY_REPEAT_EN, hold 4'hF for 800 cycles -> key_valid at acceptance, +500, +600, +700 cycles; without it -> exactly one pulse.
